mem_port_arbiter: RTL

- Shares one single-ported, variable-latency memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Sequences one outstanding memory transaction at a time. Generates per-requester stall signals that feed the hazard unit's stallF/stallD and a new memory-stage stall.
- Data has priority over fetch, with a bounded-starvation guard for fetch.
- Supports abandoning an in-flight fetch on a control-flow redirect.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters.
// Data wins by default; fetch is forced through after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          stall_fetch,
  output logic          stall_mem,
  output logic          mem_req,
  output logic          mem_we,
  output logic [2:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t          state, state_n;
  logic [3:0]      starve, starve_n;
  logic            kill_pend, kill_pend_n;
  logic            kill_now;
  logic            grant_d, grant_i;
  logic            mem_req_n, mem_we_n;
  logic [2:0]      mem_size_n;
  logic [AW-1:0]   mem_addr_n;
  logic [31:0]     mem_wdata_n;
  logic            if_ack_n, d_ack_n;
  logic [31:0]     if_rdata_n, d_rdata_n;

  assign stall_fetch = if_req & ~if_ack;
  assign stall_mem   = d_req & ~d_ack;

  always_comb begin
    state_n     = state;
    kill_pend_n = kill_pend;
    kill_now    = 1'b0;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_size_n  = mem_size;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_ack_n    = 1'b0;
    d_ack_n     = 1'b0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    unique case (state)
      IDLE: begin
        if (d_req && (!if_req || starve < SMAX)) begin
          grant_d     = 1'b1;
          state_n     = BUSY_D;
          mem_req_n   = 1'b1;
          mem_we_n    = d_we;
          mem_size_n  = d_size;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
        end else if (if_req && !if_kill) begin
          grant_i    = 1'b1;
          state_n    = BUSY_I;
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
          mem_size_n = 3'b010;
          mem_addr_n = if_addr;
        end
      end
      BUSY_I: begin
        // a kill landing on the ack cycle still suppresses the response
        kill_now    = kill_pend | if_kill;
        kill_pend_n = kill_now;
        if (mem_ack) begin
          state_n   = RESP;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          if (!kill_now) begin
            if_ack_n   = 1'b1;
            if_rdata_n = mem_rdata;
          end
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_n   = RESP;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          d_ack_n   = 1'b1;
          if (!mem_we) d_rdata_n = mem_rdata;
        end
      end
      RESP: begin
        state_n     = IDLE;
        kill_pend_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    starve_n = starve;
    if (!if_req)
      starve_n = 4'd0;
    else if (grant_i)
      starve_n = 4'd0;
    else if (grant_d && starve < SMAX)
      starve_n = starve + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      starve    <= 4'd0;
      kill_pend <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= 3'b000;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      state     <= state_n;
      starve    <= starve_n;
      kill_pend <= kill_pend_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_size  <= mem_size_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_ack    <= if_ack_n;
      d_ack     <= d_ack_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
    end
  end

endmodule
